// File: rtl/asteroids_pkg.sv
// Shared widths and vector types for the asteroids collision / scoring logic.
package asteroids_pkg;

  localparam int LIVES_W       = 2;
  localparam int POINTS_DEF    = 10;
  localparam int TORPEDOS_DEF  = 2;
  localparam int ASTEROIDS_DEF = 8;

  typedef logic [TORPEDOS_DEF-1:0]  torp_vec_t;
  typedef logic [ASTEROIDS_DEF-1:0] hit_vec_t;

endpackage

// File: rtl/hit_popcount.sv
// Combinational population count of a hit vector.
module hit_popcount #(
  parameter int N = 8
) (
  input  logic [N-1:0]             bits,
  output logic [$clog2(N+1)-1:0]   count
);

  localparam int CW = $clog2(N + 1);

  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/hit_detector.sv
// Per-frame collision accumulation between torpedoes, asteroids and the ship,
// with frame-end hit pulses plus the score and lives counters.
module hit_detector
  import asteroids_pkg::*;
#(
  parameter int TORPEDOS      = TORPEDOS_DEF,
  parameter int ASTEROIDS     = ASTEROIDS_DEF,
  parameter int SCORE_W       = 16,
  parameter int POINTS        = POINTS_DEF,
  parameter int LIVES_INIT    = 3,
  parameter int INVULN_FRAMES = 120
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 vsync,
  input  logic                 pixel_en,
  input  logic [TORPEDOS-1:0]  torpedo_draw,
  input  logic [ASTEROIDS-1:0] asteroid_draw,
  input  logic                 ship_draw,
  input  logic                 new_game,
  output logic [TORPEDOS-1:0]  torpedo_collision,
  output logic [ASTEROIDS-1:0] asteroid_hit,
  output logic                 ship_hit,
  output logic [SCORE_W-1:0]   score,
  output logic [LIVES_W-1:0]   lives,
  output logic                 game_over
);

  localparam int IW    = $clog2(INVULN_FRAMES + 1);
  localparam int CNT_W = $clog2(ASTEROIDS + 1);

  logic [TORPEDOS-1:0]  t_acc, t_cur;
  logic [ASTEROIDS-1:0] a_acc, a_cur;
  logic                 s_acc, s_cur;
  logic [IW-1:0]        invuln;
  logic [CNT_W-1:0]     hit_count;
  logic [SCORE_W:0]     score_prod, score_sum;
  logic [SCORE_W-1:0]   score_next;
  logic                 any_ast, any_torp, ship_ok;

  hit_popcount #(.N(ASTEROIDS)) u_popcount (
    .bits  (asteroid_hit),
    .count (hit_count)
  );

  // Overlaps seen this pixel; blanking cycles contribute nothing.
  always_comb begin
    any_ast  = |asteroid_draw;
    any_torp = |torpedo_draw;
    t_cur    = '0;
    a_cur    = '0;
    s_cur    = 1'b0;
    if (pixel_en) begin
      t_cur = torpedo_draw & {TORPEDOS{any_ast}};
      a_cur = asteroid_draw & {ASTEROIDS{any_torp}};
      s_cur = ship_draw & any_ast;
    end
  end

  // Extra bit of headroom so an overflowing add saturates instead of wrapping.
  always_comb begin
    score_prod = (SCORE_W+1)'(POINTS) * (SCORE_W+1)'(hit_count);
    score_sum  = {1'b0, score} + score_prod;
    score_next = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
    ship_ok    = s_acc && (invuln == '0) && !game_over;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      t_acc             <= '0;
      a_acc             <= '0;
      s_acc             <= 1'b0;
      torpedo_collision <= '0;
      asteroid_hit      <= '0;
      ship_hit          <= 1'b0;
      score             <= '0;
      lives             <= LIVES_W'(LIVES_INIT);
      game_over         <= 1'b0;
      invuln            <= '0;
    end else if (new_game) begin
      t_acc             <= '0;
      a_acc             <= '0;
      s_acc             <= 1'b0;
      torpedo_collision <= '0;
      asteroid_hit      <= '0;
      ship_hit          <= 1'b0;
      score             <= '0;
      lives             <= LIVES_W'(LIVES_INIT);
      game_over         <= 1'b0;
      invuln            <= '0;
    end else begin
      if (vsync) begin
        // Close the frame; an overlap in the vsync cycle seeds the next one.
        torpedo_collision <= t_acc;
        asteroid_hit      <= a_acc;
        ship_hit          <= ship_ok;
        t_acc             <= t_cur;
        a_acc             <= a_cur;
        s_acc             <= s_cur;
        if (ship_ok) begin
          lives     <= lives - LIVES_W'(1);
          game_over <= (lives == LIVES_W'(1));
          invuln    <= IW'(INVULN_FRAMES);
        end else if (invuln != '0) begin
          invuln <= invuln - IW'(1);
        end
      end else begin
        torpedo_collision <= '0;
        asteroid_hit      <= '0;
        ship_hit          <= 1'b0;
        t_acc             <= t_acc | t_cur;
        a_acc             <= a_acc | a_cur;
        s_acc             <= s_acc | s_cur;
      end
      if (!game_over) begin
        score <= score_next;
      end
    end
  end

endmodule

// File: tb/tb_hit_detector.sv
// Directed bench for hit_detector: frame pulses, scoring, lives, invulnerability and resets.
module tb_hit_detector;
  import asteroids_pkg::*;

  logic        clk = 1'b0;
  logic        resetN;
  logic        vsync;
  logic        pixel_en;
  torp_vec_t   torpedo_draw;
  hit_vec_t    asteroid_draw;
  logic        ship_draw;
  logic        new_game;
  torp_vec_t   torpedo_collision;
  hit_vec_t    asteroid_hit;
  logic        ship_hit;
  logic [15:0] score;
  logic [1:0]  lives;
  logic        game_over;

  int n_compared = 0;
  int n_mismatched = 0;

  hit_detector dut (
    .clk               (clk),
    .resetN            (resetN),
    .vsync             (vsync),
    .pixel_en          (pixel_en),
    .torpedo_draw      (torpedo_draw),
    .asteroid_draw     (asteroid_draw),
    .ship_draw         (ship_draw),
    .new_game          (new_game),
    .torpedo_collision (torpedo_collision),
    .asteroid_hit      (asteroid_hit),
    .ship_hit          (ship_hit),
    .score             (score),
    .lives             (lives),
    .game_over         (game_over)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input torp_vec_t t, input hit_vec_t a,
                       input logic s, input logic v);
    pixel_en      = en;
    torpedo_draw  = t;
    asteroid_draw = a;
    ship_draw     = s;
    vsync         = v;
    new_game      = 1'b0;
    tick();
    vsync    = 1'b0;
    pixel_en = 1'b0;
  endtask

  task automatic frame_end();
    drive(1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    #12;
    n_compared++;
    if (score !== 16'd0) begin n_mismatched++; $display("[TB] FAIL reset_score got %0d expected 0", score); end
    n_compared++;
    if (lives !== 2'd3) begin n_mismatched++; $display("[TB] FAIL reset_lives got %0d expected 3", lives); end
    n_compared++;
    if ({game_over, ship_hit, torpedo_collision, asteroid_hit} !== 12'h000) begin
      n_mismatched++;
      $display("[TB] FAIL reset_pulses got go=%b sh=%b tc=%b ah=%h expected all 0",
               game_over, ship_hit, torpedo_collision, asteroid_hit);
    end
    @(negedge clk);
    resetN = 1'b1;
    tick();
  endtask

  task automatic test_torpedo_hit();
    for (int i = 0; i < 4; i++) drive(1'b1, 2'b01, 8'h08, 1'b0, 1'b0);
    frame_end();
    n_compared++;
    if (torpedo_collision !== 2'b01) begin n_mismatched++; $display("[TB] FAIL hit_tc got %b expected 01", torpedo_collision); end
    n_compared++;
    if (asteroid_hit !== 8'h08) begin n_mismatched++; $display("[TB] FAIL hit_ah got %h expected 08", asteroid_hit); end
    tick();
    n_compared++;
    if (score !== 16'd10) begin n_mismatched++; $display("[TB] FAIL hit_score got %0d expected 10", score); end
    n_compared++;
    if (asteroid_hit !== 8'h00) begin n_mismatched++; $display("[TB] FAIL hit_pulse_width got %h expected 00", asteroid_hit); end
  endtask

  task automatic test_blanking();
    for (int i = 0; i < 4; i++) drive(1'b0, 2'b01, 8'h08, 1'b0, 1'b0);
    frame_end();
    n_compared++;
    if ({torpedo_collision, asteroid_hit} !== 10'h000) begin
      n_mismatched++;
      $display("[TB] FAIL blank_pulses got tc=%b ah=%h expected 0", torpedo_collision, asteroid_hit);
    end
    tick();
    n_compared++;
    if (score !== 16'd10) begin n_mismatched++; $display("[TB] FAIL blank_score got %0d expected 10", score); end
  endtask

  task automatic test_vsync_overlap();
    drive(1'b1, 2'b10, 8'h40, 1'b0, 1'b1);
    n_compared++;
    if ({torpedo_collision, asteroid_hit} !== 10'h000) begin
      n_mismatched++;
      $display("[TB] FAIL vsync_ovl_first got tc=%b ah=%h expected 0", torpedo_collision, asteroid_hit);
    end
    frame_end();
    n_compared++;
    if ({torpedo_collision, asteroid_hit} !== {2'b10, 8'h40}) begin
      n_mismatched++;
      $display("[TB] FAIL vsync_ovl_next got tc=%b ah=%h expected 10/40", torpedo_collision, asteroid_hit);
    end
    tick();
    n_compared++;
    if (score !== 16'd20) begin n_mismatched++; $display("[TB] FAIL vsync_ovl_score got %0d expected 20", score); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 2'b11, 8'h30, 1'b0, 1'b0);
    frame_end();
    n_compared++;
    if ({torpedo_collision, asteroid_hit} !== {2'b11, 8'h30}) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_first got tc=%b ah=%h expected 11/30", torpedo_collision, asteroid_hit);
    end
    frame_end();
    n_compared++;
    if ({torpedo_collision, asteroid_hit} !== 10'h000) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_second got tc=%b ah=%h expected 0", torpedo_collision, asteroid_hit);
    end
    tick();
    n_compared++;
    if (score !== 16'd40) begin n_mismatched++; $display("[TB] FAIL b2b_score got %0d expected 40", score); end
  endtask

  task automatic test_ship_invuln();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    n_compared++;
    if ({score, lives} !== {16'd0, 2'd3}) begin
      n_mismatched++;
      $display("[TB] FAIL ng_state got score=%0d lives=%0d expected 0/3", score, lives);
    end
    drive(1'b1, '0, 8'h01, 1'b1, 1'b0);
    frame_end();
    n_compared++;
    if ({ship_hit, lives} !== {1'b1, 2'd2}) begin
      n_mismatched++;
      $display("[TB] FAIL ship_first got hit=%b lives=%0d expected 1/2", ship_hit, lives);
    end
    for (int f = 0; f < 2; f++) begin
      drive(1'b1, '0, 8'h01, 1'b1, 1'b0);
      frame_end();
      n_compared++;
      if ({ship_hit, lives} !== {1'b0, 2'd2}) begin
        n_mismatched++;
        $display("[TB] FAIL ship_invuln%0d got hit=%b lives=%0d expected 0/2", f, ship_hit, lives);
      end
    end
    for (int f = 0; f < 117; f++) frame_end();
    drive(1'b1, '0, 8'h01, 1'b1, 1'b0);
    frame_end();
    n_compared++;
    if ({ship_hit, lives} !== {1'b0, 2'd2}) begin
      n_mismatched++;
      $display("[TB] FAIL ship_last_invuln got hit=%b lives=%0d expected 0/2", ship_hit, lives);
    end
    drive(1'b1, '0, 8'h01, 1'b1, 1'b0);
    frame_end();
    n_compared++;
    if ({ship_hit, lives, game_over} !== {1'b1, 2'd1, 1'b0}) begin
      n_mismatched++;
      $display("[TB] FAIL ship_second got hit=%b lives=%0d go=%b expected 1/1/0", ship_hit, lives, game_over);
    end
  endtask

  task automatic test_game_over();
    for (int f = 0; f < 121; f++) frame_end();
    drive(1'b1, '0, 8'h02, 1'b1, 1'b0);
    frame_end();
    n_compared++;
    if ({ship_hit, lives, game_over} !== {1'b1, 2'd0, 1'b1}) begin
      n_mismatched++;
      $display("[TB] FAIL go_enter got hit=%b lives=%0d go=%b expected 1/0/1", ship_hit, lives, game_over);
    end
    drive(1'b1, 2'b10, 8'h21, 1'b0, 1'b0);
    frame_end();
    n_compared++;
    if ({torpedo_collision, asteroid_hit} !== {2'b10, 8'h21}) begin
      n_mismatched++;
      $display("[TB] FAIL go_pulses got tc=%b ah=%h expected 10/21", torpedo_collision, asteroid_hit);
    end
    tick();
    n_compared++;
    if (score !== 16'd0) begin n_mismatched++; $display("[TB] FAIL go_score got %0d expected 0", score); end
    for (int f = 0; f < 121; f++) frame_end();
    drive(1'b1, '0, 8'h01, 1'b1, 1'b0);
    frame_end();
    n_compared++;
    if ({ship_hit, lives, game_over} !== {1'b0, 2'd0, 1'b1}) begin
      n_mismatched++;
      $display("[TB] FAIL go_ship got hit=%b lives=%0d go=%b expected 0/0/1", ship_hit, lives, game_over);
    end
  endtask

  task automatic test_new_game_vsync();
    drive(1'b1, 2'b01, 8'h04, 1'b1, 1'b0);
    pixel_en = 1'b0;
    vsync    = 1'b1;
    new_game = 1'b1;
    tick();
    vsync    = 1'b0;
    new_game = 1'b0;
    n_compared++;
    if ({torpedo_collision, asteroid_hit, ship_hit} !== 11'h000) begin
      n_mismatched++;
      $display("[TB] FAIL ngv_pulses got tc=%b ah=%h sh=%b expected 0", torpedo_collision, asteroid_hit, ship_hit);
    end
    n_compared++;
    if ({score, lives, game_over} !== {16'd0, 2'd3, 1'b0}) begin
      n_mismatched++;
      $display("[TB] FAIL ngv_state got score=%0d lives=%0d go=%b expected 0/3/0", score, lives, game_over);
    end
    frame_end();
    n_compared++;
    if ({torpedo_collision, asteroid_hit, ship_hit} !== 11'h000) begin
      n_mismatched++;
      $display("[TB] FAIL ngv_cleared got tc=%b ah=%h sh=%b expected 0", torpedo_collision, asteroid_hit, ship_hit);
    end
  endtask

  task automatic test_saturation();
    for (int f = 0; f < 819; f++) begin
      drive(1'b1, 2'b01, 8'hFF, 1'b0, 1'b0);
      frame_end();
    end
    tick();
    n_compared++;
    if (score !== 16'd65520) begin n_mismatched++; $display("[TB] FAIL sat_bulk got %0d expected 65520", score); end
    drive(1'b1, 2'b01, 8'h01, 1'b0, 1'b0);
    frame_end();
    tick();
    n_compared++;
    if (score !== 16'd65530) begin n_mismatched++; $display("[TB] FAIL sat_pre got %0d expected 65530", score); end
    drive(1'b1, 2'b01, 8'h03, 1'b0, 1'b0);
    frame_end();
    tick();
    n_compared++;
    if (score !== 16'd65535) begin n_mismatched++; $display("[TB] FAIL sat_clip got %0d expected 65535", score); end
    drive(1'b1, 2'b01, 8'hFF, 1'b0, 1'b0);
    frame_end();
    tick();
    n_compared++;
    if (score !== 16'd65535) begin n_mismatched++; $display("[TB] FAIL sat_hold got %0d expected 65535", score); end
  endtask

  task automatic test_reset_midframe();
    drive(1'b1, 2'b01, 8'h08, 1'b1, 1'b0);
    drive(1'b1, 2'b01, 8'h08, 1'b1, 1'b1);
    #2;
    resetN = 1'b0;
    #1;
    n_compared++;
    if ({torpedo_collision, asteroid_hit, ship_hit, game_over} !== 12'h000) begin
      n_mismatched++;
      $display("[TB] FAIL rst_mid_pulses got tc=%b ah=%h sh=%b go=%b expected 0",
               torpedo_collision, asteroid_hit, ship_hit, game_over);
    end
    n_compared++;
    if ({score, lives} !== {16'd0, 2'd3}) begin
      n_mismatched++;
      $display("[TB] FAIL rst_mid_state got score=%0d lives=%0d expected 0/3", score, lives);
    end
    #3;
    resetN = 1'b1;
    frame_end();
    n_compared++;
    if ({torpedo_collision, asteroid_hit, ship_hit} !== 11'h000) begin
      n_mismatched++;
      $display("[TB] FAIL rst_mid_acc got tc=%b ah=%h sh=%b expected 0", torpedo_collision, asteroid_hit, ship_hit);
    end
  endtask

  initial begin
    resetN        = 1'b0;
    vsync         = 1'b0;
    pixel_en      = 1'b0;
    torpedo_draw  = '0;
    asteroid_draw = '0;
    ship_draw     = 1'b0;
    new_game      = 1'b0;
    test_reset();
    test_torpedo_hit();
    test_blanking();
    test_vsync_overlap();
    test_back_to_back();
    test_ship_invuln();
    test_game_over();
    test_new_game_vsync();
    test_saturation();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
